// File: rtl/eccop_amm_wbuf.sv
// Posted-write buffer between the AHB-to-AMM bridge and the ECC engine: writes retire at zero waits,
// reads wait for the buffer to drain. Optional occupancy statistics under `ECCOP_WBUF_STATS_EN.
module eccop_amm_wbuf #(
  parameter int P_DEPTH = 4,
  parameter int P_AW    = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [P_AW-1:0]       s_address,
  input  logic [31:0]           s_writedata,
  input  logic [3:0]            s_byteenable,
  input  logic                  s_write,
  input  logic                  s_read,
  output logic [31:0]           s_readdata,
  output logic                  s_waitrequest,
  output logic [P_AW-1:0]       m_address,
  output logic [31:0]           m_writedata,
  output logic [3:0]            m_byteenable,
  output logic                  m_write,
  output logic                  m_read,
  input  logic [31:0]           m_readdata,
  input  logic                  m_waitrequest
`ifdef ECCOP_WBUF_STATS_EN
  ,
  output logic [$clog2(P_DEPTH):0] wbuf_level,
  output logic [$clog2(P_DEPTH):0] wbuf_hiwater
`endif
);

  localparam int LP_PW = $clog2(P_DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [P_AW-1:0]   r_fifo_addr [P_DEPTH];
  logic [31:0]       r_fifo_data [P_DEPTH];
  logic [3:0]        r_fifo_be   [P_DEPTH];

  logic [LP_PW-1:0]  r_wptr;
  logic [LP_PW-1:0]  r_rptr;
  logic [LP_PW-1:0]  w_wptr_nxt;
  logic [LP_PW-1:0]  w_rptr_nxt;
  logic [LP_PW-2:0]  w_widx;
  logic [LP_PW-2:0]  w_ridx;
  logic [P_AW-1:0]   r_rd_addr;
  logic [31:0]       r_rdata;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_rd_start;
  logic              w_rd_capture;

  assign w_widx  = r_wptr[LP_PW-2:0];
  assign w_ridx  = r_rptr[LP_PW-2:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[LP_PW-1] != r_rptr[LP_PW-1]) &&
                   (r_wptr[LP_PW-2:0] == r_rptr[LP_PW-2:0]);

  // Full comes from registered pointers only, so a same-cycle pop never releases a stalled write.
  assign w_push     = s_write && !w_full;
  assign m_write    = !w_empty && (r_state != ST_RD_ISSUE);
  assign w_pop      = m_write && !m_waitrequest;
  assign w_wptr_nxt = r_wptr + {{(LP_PW-1){1'b0}}, w_push};
  assign w_rptr_nxt = r_rptr + {{(LP_PW-1){1'b0}}, w_pop};

  assign m_read        = (r_state == ST_RD_ISSUE);
  assign m_address     = m_read ? r_rd_addr : r_fifo_addr[w_ridx];
  assign m_writedata   = r_fifo_data[w_ridx];
  assign m_byteenable  = m_read ? 4'hF : r_fifo_be[w_ridx];
  assign s_readdata    = r_rdata;
  assign s_waitrequest = s_read ? (r_state != ST_RD_DONE) : w_full;

  always_ff @(posedge hclk) begin
    if (w_push) begin
      r_fifo_addr[w_widx] <= s_address;
      r_fifo_data[w_widx] <= s_writedata;
      r_fifo_be[w_widx]   <= s_byteenable;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_state   <= ST_IDLE;
      r_rd_addr <= '0;
      r_rdata   <= '0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_state <= w_state_nxt;
      if (w_rd_start) begin
        r_rd_addr <= s_address;
      end
      if (w_rd_capture) begin
        r_rdata <= m_readdata;
      end
    end
  end

  // A read only starts once every earlier write has left for the engine.
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_start   = 1'b0;
    w_rd_capture = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (s_read && w_empty && !s_write) begin
          w_rd_start  = 1'b1;
          w_state_nxt = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        if (!m_waitrequest) begin
          w_rd_capture = 1'b1;
          w_state_nxt  = ST_RD_DONE;
        end
      end
      ST_RD_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef ECCOP_WBUF_STATS_EN
  logic [LP_PW-1:0] r_level;
  logic [LP_PW-1:0] r_hiwater;
  logic [LP_PW-1:0] w_level_nxt;

  // Pointer difference modulo 2*P_DEPTH is the occupancy after this edge.
  assign w_level_nxt  = w_wptr_nxt - w_rptr_nxt;
  assign wbuf_level   = r_level;
  assign wbuf_hiwater = r_hiwater;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_level   <= '0;
      r_hiwater <= '0;
    end else begin
      r_level <= w_level_nxt;
      if (w_level_nxt > r_hiwater) begin
        r_hiwater <= w_level_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eccop_amm_wbuf.sv
// Bench for eccop_amm_wbuf: queue-based reference of the buffer and read ordering, checked every
// falling edge, plus directed scenarios with literal expectations.
module tb_eccop_amm_wbuf;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          hclk;
  logic          hresetn;
  logic [AW-1:0] s_address;
  logic [31:0]   s_writedata;
  logic [3:0]    s_byteenable;
  logic          s_write;
  logic          s_read;
  logic [31:0]   s_readdata;
  logic          s_waitrequest;
  logic [AW-1:0] m_address;
  logic [31:0]   m_writedata;
  logic [3:0]    m_byteenable;
  logic          m_write;
  logic          m_read;
  logic [31:0]   m_readdata;
  logic          m_waitrequest;
`ifdef ECCOP_WBUF_STATS_EN
  logic [2:0]    wbuf_level;
  logic [2:0]    wbuf_hiwater;
`endif

  eccop_amm_wbuf #(.P_DEPTH(DEPTH), .P_AW(AW)) dut (
    .hclk          (hclk),
    .hresetn       (hresetn),
    .s_address     (s_address),
    .s_writedata   (s_writedata),
    .s_byteenable  (s_byteenable),
    .s_write       (s_write),
    .s_read        (s_read),
    .s_readdata    (s_readdata),
    .s_waitrequest (s_waitrequest),
    .m_address     (m_address),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_write       (m_write),
    .m_read        (m_read),
    .m_readdata    (m_readdata),
    .m_waitrequest (m_waitrequest)
`ifdef ECCOP_WBUF_STATS_EN
    ,
    .wbuf_level    (wbuf_level),
    .wbuf_hiwater  (wbuf_hiwater)
`endif
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    int          cyc;
  } log_t;

  ent_t        mq[$];     // writes the buffer should be holding, oldest first
  log_t        elog[$];   // writes the engine actually accepted
  int          rd_ph;     // 0: no read, 1: read outstanding at engine, 2: data handed back
  logic [31:0] rd_a;
  logic [31:0] rd_data;
  int          m_hi;
  int          cyc;
  int          n_eng_rd;
  int          n_chk;
  int          n_pass;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
  endtask

  // Reference model, advanced at every rising edge from the bench-driven inputs.
  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      mq.delete();
      rd_ph   = 0;
      rd_a    = '0;
      rd_data = '0;
      m_hi    = 0;
    end else begin
      bit pop, push, was_empty;
      cyc++;
      if (m_write && !m_waitrequest)
        elog.push_back('{a: m_address, d: m_writedata, be: m_byteenable, cyc: cyc});
      if (m_read && !m_waitrequest) n_eng_rd++;
      was_empty = (mq.size() == 0);
      pop  = !was_empty && (rd_ph != 1) && !m_waitrequest;
      push = s_write && (mq.size() < DEPTH);
      case (rd_ph)
        0: if (s_read && was_empty && !s_write) begin rd_ph = 1; rd_a = s_address; end
        1: if (!m_waitrequest) begin rd_ph = 2; rd_data = m_readdata; end
        default: rd_ph = 0;
      endcase
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{a: s_address, d: s_writedata, be: s_byteenable});
      if (mq.size() > m_hi) m_hi = mq.size();
    end
  end

  always @(negedge hclk) begin
    bit emw, emr;
    emw = (mq.size() > 0) && (rd_ph != 1);
    emr = (rd_ph == 1);
    chk("m_write", 32'(m_write), 32'(emw));
    chk("m_read", 32'(m_read), 32'(emr));
    chk("s_waitrequest", 32'(s_waitrequest),
        32'(s_read ? (rd_ph != 2) : (mq.size() == DEPTH)));
    chk("s_readdata", s_readdata, rd_data);
    if (emw) begin
      chk("m_address_wr", m_address, mq[0].a);
      chk("m_writedata", m_writedata, mq[0].d);
      chk("m_byteenable_wr", 32'(m_byteenable), 32'(mq[0].be));
    end else if (emr) begin
      chk("m_address_rd", m_address, rd_a);
      chk("m_byteenable_rd", 32'(m_byteenable), 32'hF);
    end
`ifdef ECCOP_WBUF_STATS_EN
    chk("wbuf_level", 32'(wbuf_level), 32'(mq.size()));
    chk("wbuf_hiwater", 32'(wbuf_hiwater), 32'(m_hi));
`endif
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int stalls);
    logic w;
    bit   acc;
    s_write      = 1'b1;
    s_address    = a;
    s_writedata  = d;
    s_byteenable = 4'hF;
    stalls = 0;
    acc    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      w = s_waitrequest;
      @(posedge hclk);
      #1;
      if (!w) begin acc = 1'b1; break; end
      stalls++;
    end
    if (!acc) chk("write_accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int st, base, rb;
    bit seen, done;
    logic [31:0] got;
    n_chk = 0; n_pass = 0; cyc = 0; n_eng_rd = 0;
    hresetn = 1'b0;
    s_address = '0; s_writedata = '0; s_byteenable = '0;
    s_write = 1'b0; s_read = 1'b0;
    m_readdata = '0; m_waitrequest = 1'b0;
    repeat (2) tick();
    chk("rst_m_write", 32'(m_write), 32'd0);
    chk("rst_m_read", 32'(m_read), 32'd0);
    chk("rst_s_readdata", s_readdata, 32'd0);
    chk("rst_s_waitrequest", 32'(s_waitrequest), 32'd0);
    hresetn = 1'b1;
    tick();

    // Zero-wait drain
    m_waitrequest = 1'b0;
    do_write(32'h10, 32'hA1, st); chk("t1_stall0", 32'(st), 32'd0);
    do_write(32'h14, 32'hA2, st); chk("t1_stall1", 32'(st), 32'd0);
    do_write(32'h18, 32'hA3, st); chk("t1_stall2", 32'(st), 32'd0);
    s_write = 1'b0;
    repeat (3) tick();
    chk("t1_count", 32'(elog.size()), 32'd3);
    chk("t1_addr0", elog[0].a, 32'h10);
    chk("t1_data0", elog[0].d, 32'hA1);
    chk("t1_addr1", elog[1].a, 32'h14);
    chk("t1_data2", elog[2].d, 32'hA3);
    chk("t1_back_to_back", 32'(elog[2].cyc - elog[0].cyc), 32'd2);

    // Full stall
    m_waitrequest = 1'b1;
    base = elog.size();
    for (int i = 0; i < 4; i++) begin
      do_write(32'h100 + 32'(4 * i), 32'hB0 + 32'(i), st);
      chk("t2_fill_nostall", 32'(st), 32'd0);
    end
    s_write = 1'b1; s_address = 32'h110; s_writedata = 32'hB4; s_byteenable = 4'h3;
    repeat (3) tick();
    chk("t2_full_stall", 32'(s_waitrequest), 32'd1);
    m_waitrequest = 1'b0;
    #1 chk("t2_pop_cycle_still_stalled", 32'(s_waitrequest), 32'd1);
    tick();
    chk("t2_unstall_after_pop", 32'(s_waitrequest), 32'd0);
    tick();
    s_write = 1'b0;
    repeat (6) tick();
    chk("t2_count", 32'(elog.size() - base), 32'd5);
    chk("t2_first", elog[base].a, 32'h100);
    chk("t2_fifth_addr", elog[base + 4].a, 32'h110);
    chk("t2_fifth_be", 32'(elog[base + 4].be), 32'h3);

    // Ordered read behind two buffered writes
    m_waitrequest = 1'b1;
    base = elog.size();
    do_write(32'h40, 32'hC0, st);
    do_write(32'h44, 32'hC1, st);
    s_write = 1'b0;
    s_read = 1'b1; s_address = 32'h20; m_readdata = 32'hCAFEF00D;
    repeat (4) tick();
    chk("t3_no_early_read", 32'(elog.size() - base), 32'd0);
    m_waitrequest = 1'b0;
    seen = 1'b0; done = 1'b0; got = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (m_read && !seen) begin
        seen = 1'b1;
        chk("t3_drained_before_read", 32'(elog.size() - base), 32'd2);
      end
      if (!s_waitrequest) begin got = s_readdata; done = 1'b1; break; end
    end
    chk("t3_read_done", 32'(done), 32'd1);
    chk("t3_read_seen", 32'(seen), 32'd1);
    chk("t3_readdata", got, 32'hCAFEF00D);
    tick();
    s_read = 1'b0;
    tick();

    // Minimum read latency
    m_waitrequest = 1'b0;
    m_readdata = 32'h12345678;
    rb = n_eng_rd;
    s_read = 1'b1; s_address = 32'h04;
    #1 chk("t4_c0_m_read", 32'(m_read), 32'd0);
    tick();
    chk("t4_c1_m_read", 32'(m_read), 32'd1);
    chk("t4_c1_m_address", m_address, 32'h04);
    chk("t4_c1_wait", 32'(s_waitrequest), 32'd1);
    tick();
    chk("t4_c2_m_read", 32'(m_read), 32'd0);
    chk("t4_c2_wait", 32'(s_waitrequest), 32'd0);
    chk("t4_c2_data", s_readdata, 32'h12345678);
    tick();
    s_read = 1'b0;
    repeat (2) tick();
    chk("t4_one_engine_read", 32'(n_eng_rd - rb), 32'd1);
    chk("t4_data_held", s_readdata, 32'h12345678);

    // Reset with writes buffered and a read waiting behind them
    m_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) do_write(32'h200 + 32'(4 * i), 32'hD0 + 32'(i), st);
    s_write = 1'b0;
    s_read = 1'b1; s_address = 32'h30;
    repeat (2) tick();
    chk("t5_pre_m_write", 32'(m_write), 32'd1);
    #3 hresetn = 1'b0;
    #1;
    chk("t5_rst_m_write", 32'(m_write), 32'd0);
    chk("t5_rst_m_read", 32'(m_read), 32'd0);
    chk("t5_rst_readdata", s_readdata, 32'd0);
    s_read = 1'b0; m_waitrequest = 1'b0;
    repeat (2) tick();
    hresetn = 1'b1;
    base = elog.size(); rb = n_eng_rd;
    repeat (6) tick();
    chk("t5_no_writes_after", 32'(elog.size() - base), 32'd0);
    chk("t5_no_reads_after", 32'(n_eng_rd - rb), 32'd0);

    // Reset with an engine read outstanding
    m_waitrequest = 1'b1;
    s_read = 1'b1; s_address = 32'h34;
    repeat (2) tick();
    chk("t5b_pre_m_read", 32'(m_read), 32'd1);
    #3 hresetn = 1'b0;
    #1 chk("t5b_rst_m_read", 32'(m_read), 32'd0);
    s_read = 1'b0; m_waitrequest = 1'b0;
    tick();
    hresetn = 1'b1;
    rb = n_eng_rd; base = elog.size();
    repeat (4) tick();
    chk("t5b_no_reads_after", 32'(n_eng_rd - rb), 32'd0);
    chk("t5b_no_writes_after", 32'(elog.size() - base), 32'd0);

`ifdef ECCOP_WBUF_STATS_EN
    // Occupancy statistics
    m_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) do_write(32'h300 + 32'(4 * i), 32'hE0 + 32'(i), st);
    s_write = 1'b0;
    chk("t6_level3", 32'(wbuf_level), 32'd3);
    chk("t6_hiwater3", 32'(wbuf_hiwater), 32'd3);
    m_waitrequest = 1'b0;
    repeat (5) tick();
    chk("t6_level0", 32'(wbuf_level), 32'd0);
    chk("t6_hiwater_held", 32'(wbuf_hiwater), 32'd3);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
